ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx.sv | 151 +++++++++++++++
 tb/tb_ps2_frame_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and de-glitches the PS/2
// clock, deserializes 11-bit frames and reports good bytes or frame errors.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2;
    logic          data_s1, data_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [TW-1:0] timer, tmr_n;
    logic [7:0]    shreg, sh_n;
    logic          par_bit, par_n;
    logic [7:0]    code_n;
    logic          rdy_n, perr_n, ferr_n;

    // Synchronizers and clock filter; fall is registered alongside the flip
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1  <= keyb_clk;
            clk_s2  <= clk_s1;
            data_s1 <= keyb_data;
            data_s2 <= data_s1;
            fall    <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                filt_clk <= clk_s2;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            timer      <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            scan_code  <= 8'h00;
            scan_ready <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_n;
            timer      <= tmr_n;
            shreg      <= sh_n;
            par_bit    <= par_n;
            scan_code  <= code_n;
            scan_ready <= rdy_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        tmr_n   = timer;
        sh_n    = shreg;
        par_n   = par_bit;
        code_n  = scan_code;
        rdy_n   = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        if (state != IDLE) begin
            tmr_n = timer + TW'(1);
        end
        unique case (state)
            IDLE: begin
                if (fall && !data_s2) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tmr_n   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    sh_n[bit_cnt] = data_s2;
                    tmr_n         = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = data_s2;
                    tmr_n   = '0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                    // A bad stop bit dominates a parity failure
                    if (!data_s2) begin
                        ferr_n = 1'b1;
                    end else if (^{shreg, par_bit}) begin
                        code_n = shreg;
                        rdy_n  = 1'b1;
                    end else begin
                        perr_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !fall && timer == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            tmr_n   = '0;
            ferr_n  = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx with an expected-event scoreboard.
module tb_ps2_frame_rx;

    localparam int TMO  = 2000;
    localparam int HALF = 40;

    localparam logic [2:0] K_GOOD = 3'b100;
    localparam logic [2:0] K_PAR  = 3'b010;
    localparam logic [2:0] K_FRM  = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keyb_clk = 1'b1;
    logic       keyb_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_ready, parity_err, frame_err;

    exp_t sb[$];
    exp_t got_e;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   seen = 0;

    ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .keyb_clk(keyb_clk),
        .keyb_data(keyb_data),
        .scan_code(scan_code),
        .scan_ready(scan_ready),
        .parity_err(parity_err),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] code);
        exp_t e;
        e.kind = kind;
        e.code = code;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int nbits);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            keyb_data = f[i];
            repeat (HALF) @(posedge clk);
            keyb_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            keyb_clk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        keyb_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && (scan_ready || parity_err || frame_err)) begin
            seen++;
            check("exclusive", 32'($countones({scan_ready, parity_err,
                  frame_err})), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_strobe",
                      {29'd0, scan_ready, parity_err, frame_err}, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("strobe_kind", {29'd0, scan_ready, parity_err,
                      frame_err}, {29'd0, got_e.kind});
                check("strobe_code", {24'd0, scan_code},
                      {24'd0, got_e.code});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_code", {24'd0, scan_code}, 32'h00);
        check("rst_strobes", {29'd0, scan_ready, parity_err, frame_err}, 0);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        expect_ev(K_GOOD, 8'h16);
        send_frame(8'h16, 1'b0, 1'b1, 11);
        check("good_16", {24'd0, scan_code}, 32'h16);

        expect_ev(K_PAR, 8'h16);
        send_frame(8'h1E, 1'b0, 1'b1, 11);
        check("par_hold", {24'd0, scan_code}, 32'h16);

        expect_ev(K_FRM, 8'h16);
        send_frame(8'h5A, 1'b1, 1'b0, 11);
        check("stop_hold", {24'd0, scan_code}, 32'h16);

        expect_ev(K_GOOD, 8'h55);
        send_frame(8'h55, 1'b1, 1'b1, 11);
        check("good_55", {24'd0, scan_code}, 32'h55);

        keyb_clk = 1'b0;
        repeat (3) @(posedge clk);
        keyb_clk = 1'b1;
        repeat (30) @(posedge clk);
        expect_ev(K_GOOD, 8'h16);
        send_frame(8'h16, 1'b0, 1'b1, 11);
        check("glitch_16", {24'd0, scan_code}, 32'h16);

        expect_ev(K_FRM, 8'h16);
        send_frame(8'h1E, 1'b0, 1'b0, 11);
        check("both_bad_hold", {24'd0, scan_code}, 32'h16);

        expect_ev(K_FRM, 8'h16);
        send_frame(8'h1E, 1'b1, 1'b1, 5);
        repeat (TMO + 100) @(posedge clk);
        check("tmo_drained", 32'(sb.size()), 32'd0);

        expect_ev(K_GOOD, 8'h1E);
        send_frame(8'h1E, 1'b1, 1'b1, 11);
        check("good_1e", {24'd0, scan_code}, 32'h1E);

        send_frame(8'h16, 1'b0, 1'b1, 6);
        keyb_data = 1'b1;
        repeat (10) @(posedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_code", {24'd0, scan_code}, 32'h00);
        check("midrst_strobes",
              {29'd0, scan_ready, parity_err, frame_err}, 0);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        check("post_rst_code", {24'd0, scan_code}, 32'h00);

        expect_ev(K_GOOD, 8'h16);
        send_frame(8'h16, 1'b0, 1'b1, 11);
        check("final_16", {24'd0, scan_code}, 32'h16);

        repeat (100) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("event_count", 32'(seen), 32'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
